scroll_display: RTL
===================

# scroll_display

Parametrised scrolling message engine for the multiplexed 7-segment path. Holds a writable message of `MSG_LEN` symbols and presents a rotating window of `DIGITS` symbols, advancing one position per scroll tick. Sits between the message source (switches/controller) and the per-digit decoder/multiplexer. Generalises the fixed 7-symbol/4-digit rotator with its own position counter, a prescaler, direction control, pause/restart and a runtime message load.

## Interface
- `SYM_W`, 5, symbol width in bits
- `MSG_LEN`, 7, message length in symbols (≥2)
- `DIGITS`, 4, display digits (1..MSG_LEN)
- `TICK_DIV`, 50_000_000, clocks per scroll step (≥1)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  scrolling enable
- `pause`  in  1  freeze prescaler and position
- `restart`  in  1  sync pulse: position and prescaler to 0
- `dir`  in  1  0 = shift toward higher digit index, 1 = toward lower
- `msg_wr`  in  1  message write strobe
- `msg_addr`  in  $clog2(MSG_LEN)  write index
- `msg_data`  in  SYM_W  write symbol
- `seg_out`  out  DIGITS*SYM_W  digit k at bits [k*SYM_W +: SYM_W]
- `pos`  out  $clog2(MSG_LEN)  current offset
- `wrap`  out  1  one-cycle pulse when offset wraps

## Operation
- Message RAM: `MSG_LEN` registers; `msg_wr` writes `msg_data` to `msg_addr` on the clock edge; `msg_addr` ≥ `MSG_LEN` ignored.
- Mapping: digit k = msg[(k − pos) mod MSG_LEN]; with pos = 1: digit0 = msg[MSG_LEN−1], digit1 = msg[0].
- Prescaler `tcnt` counts 0..TICK_DIV−1 while `en` & !`pause`; step fires on terminal count, then `tcnt` → 0.
- Step: dir = 0 → pos+1, MSG_LEN−1 wraps to 0; dir = 1 → pos−1, 0 wraps to MSG_LEN−1. `wrap` asserted in the cycle after a wrapping step.
- `en` = 0: `tcnt` cleared, pos held. `pause` = 1: `tcnt` and pos held.
- Priority: `rst_n` > `restart` > step. `restart` coincident with step: pos = 0, no `wrap`.
- `msg_wr` coincident with step: both take effect; `seg_out` reflects new symbol and new pos together.
- `dir` sampled at the step edge only.

## Timing
- Reset values: pos = 0, `tcnt` = 0, message = all zeros, `seg_out` = 0, `wrap` = 0.
- `seg_out` registered: one cycle after any pos or message update.
- Step period exactly TICK_DIV clocks under continuous `en`; first step TICK_DIV clocks after `en` rises.
- `rst_n` assertion mid-scroll clears all state immediately (async); release synchronised by system reset tree.

## Configuration
- `SCROLL_BOUNCE_EN` defined: adds input `bounce` (1 bit). When `bounce` = 1 and MSG_LEN > DIGITS, internal direction replaces `dir`, pos ping-pongs 0..MSG_LEN−DIGITS, reversing at each end (no wrap, `wrap` pulses at each reversal); MSG_LEN = DIGITS holds pos at 0. `bounce` = 0 behaves as without macro; rising `bounce` initialises internal direction from `dir`.
- Undefined: no `bounce` port, rotation only.

## Structure
- Package `scroll_pkg`: `sym_t` (logic [SYM_W−1:0]), `SYM_BLANK` = 0, direction constants `DIR_UP`/`DIR_DOWN`.
- Sub-module `scroll_tick_gen` (prescaler: `en`, `hold`, `clr` → `tick`); window mux and position logic in top.

## Test plan
- MSG_LEN=7, DIGITS=4, TICK_DIV=4; load msg = 1..7, en=1, dir=0 → after 4 clocks pos=1, seg_out digits 0..3 = 7,1,2,3.
- Continue 6 more steps → pos=0, `wrap` high exactly one cycle, digits = 1,2,3,4.
- From pos=0, dir=1, one step → pos=6, digits = 2,3,4,5.
- pause high at tcnt=2 for 10 clocks → no step; step lands 2 clocks after pause falls.
- restart coincident with step at pos=6, dir=0 → pos=0, `wrap`=0; msg_wr addr 0 = 9 same cycle → digit0 = 9 next cycle.
- rst_n low mid-scroll at pos=3 → pos, seg_out, wrap zero immediately; bounce build: pos sequence 0,1,2,3,2,1,0.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling message engine.
// Optional feature macro used by scroll_display: SCROLL_BOUNCE_EN.
package scroll_pkg;

    localparam int SYM_W_DFLT = 5;

    typedef logic [SYM_W_DFLT-1:0] sym_t;

    localparam sym_t SYM_BLANK = 5'd0;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Message index shown on digit k for offset p: (k - p) mod len, with p < len and k < len.
    function automatic int win_index(input int k, input int p, input int len);
        int d;
        d = k - p;
        if (d < 0) begin
            d = d + len;
        end else begin
            d = d;
        end
        return d;
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll prescaler: counts 0..TICK_DIV-1 and flags the terminal count as a step.
// clr wins over hold; tick is combinational so the step lands on the terminal edge.
module scroll_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;

    assign tick = en && !clr && !hold && (tcnt_q == TERM);

    // Prescaler next-state: clear, hold, roll over at terminal count, or count up.
    always_comb begin
        tcnt_d = tcnt_q;
        if (clr) begin
            tcnt_d = {CNT_W{1'b0}};
        end else if (hold) begin
            tcnt_d = tcnt_q;
        end else if (tcnt_q == TERM) begin
            tcnt_d = {CNT_W{1'b0}};
        end else begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= {CNT_W{1'b0}};
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/scroll_display.sv
// Scrolling message engine: writable message RAM, rotating DIGITS-wide window, registered outputs.
// Define SCROLL_BOUNCE_EN to add the 'bounce' input (ping-pong scrolling instead of rotation).
module scroll_display
    import scroll_pkg::*;
#(
    parameter int SYM_W    = 5,
    parameter int MSG_LEN  = 7,
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        pause,
    input  logic                        restart,
    input  logic                        dir,
    input  logic                        msg_wr,
    input  logic [$clog2(MSG_LEN)-1:0]  msg_addr,
    input  logic [SYM_W-1:0]            msg_data,
`ifdef SCROLL_BOUNCE_EN
    input  logic                        bounce,
`endif
    output logic [DIGITS*SYM_W-1:0]     seg_out,
    output logic [$clog2(MSG_LEN)-1:0]  pos,
    output logic                        wrap
);

    localparam int PW = $clog2(MSG_LEN);
    localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);

    logic [SYM_W-1:0]        msg_q [MSG_LEN];
    logic [PW-1:0]           pos_q, pos_d;
    logic                    wrap_q, wrap_d;
    logic [DIGITS*SYM_W-1:0] seg_q, seg_d;
    logic                    tick_s;
    logic                    clr_s;
    logic [PW-1:0]           rot_pos_s, step_pos_s;
    logic                    rot_wrap_s, step_wrap_s;

    assign clr_s = restart || !en;

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .hold  (pause),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Rotation step: modular increment or decrement of the offset, flagging the wrap.
    always_comb begin
        rot_pos_s  = pos_q;
        rot_wrap_s = 1'b0;
        if (dir == DIR_DOWN) begin
            if (pos_q == POS_ZERO) begin
                rot_pos_s  = POS_LAST;
                rot_wrap_s = 1'b1;
            end else begin
                rot_pos_s  = pos_q - PW'(1);
                rot_wrap_s = 1'b0;
            end
        end else begin
            if (pos_q >= POS_LAST) begin
                rot_pos_s  = POS_ZERO;
                rot_wrap_s = 1'b1;
            end else begin
                rot_pos_s  = pos_q + PW'(1);
                rot_wrap_s = 1'b0;
            end
        end
    end

`ifdef SCROLL_BOUNCE_EN
    localparam logic [PW-1:0] POS_BMAX   = PW'((MSG_LEN > DIGITS) ? (MSG_LEN - DIGITS) : 0);
    localparam bit            CAN_BOUNCE = (MSG_LEN > DIGITS);

    logic          bounce_q;
    logic          bdir_q, bdir_d, bdir_s, bnc_dir_s;
    logic [PW-1:0] bnc_pos_s;
    logic          bnc_wrap_s;

    // Ping-pong step between 0 and MSG_LEN-DIGITS; direction seeded from dir when bounce rises.
    always_comb begin
        bdir_s     = (bounce && !bounce_q) ? dir : bdir_q;
        bnc_dir_s  = bdir_s;
        bnc_pos_s  = pos_q;
        bnc_wrap_s = 1'b0;
        if (!CAN_BOUNCE) begin
            bnc_pos_s = POS_ZERO;
        end else if (bdir_s == DIR_DOWN) begin
            if (pos_q == POS_ZERO) begin
                bnc_pos_s  = PW'(1);
                bnc_dir_s  = DIR_UP;
                bnc_wrap_s = 1'b1;
            end else begin
                bnc_pos_s  = pos_q - PW'(1);
            end
        end else begin
            if (pos_q >= POS_BMAX) begin
                bnc_pos_s  = pos_q - PW'(1);
                bnc_dir_s  = DIR_DOWN;
                bnc_wrap_s = 1'b1;
            end else begin
                bnc_pos_s  = pos_q + PW'(1);
            end
        end
    end

    assign step_pos_s  = bounce ? bnc_pos_s  : rot_pos_s;
    assign step_wrap_s = bounce ? bnc_wrap_s : rot_wrap_s;
    assign bdir_d      = (tick_s && !restart && bounce) ? bnc_dir_s : bdir_s;

    // Bounce direction and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounce_q <= 1'b0;
            bdir_q   <= DIR_UP;
        end else begin
            bounce_q <= bounce;
            bdir_q   <= bdir_d;
        end
    end
`else
    assign step_pos_s  = rot_pos_s;
    assign step_wrap_s = rot_wrap_s;
`endif

    // Offset next-state: restart beats a coincident step and suppresses its wrap.
    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (restart) begin
            pos_d  = POS_ZERO;
            wrap_d = 1'b0;
        end else if (tick_s) begin
            pos_d  = step_pos_s;
            wrap_d = step_wrap_s;
        end else begin
            pos_d  = pos_q;
            wrap_d = 1'b0;
        end
    end

    // Window mux: digit k shows msg[(k - pos) mod MSG_LEN].
    always_comb begin
        seg_d = {(DIGITS*SYM_W){1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            seg_d[k*SYM_W +: SYM_W] = msg_q[PW'(win_index(k, int'(pos_q), MSG_LEN))];
        end
    end

    // Message RAM; out-of-range write addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= {SYM_W{1'b0}};
            end
        end else if (msg_wr && (int'(msg_addr) < MSG_LEN)) begin
            msg_q[msg_addr] <= msg_data;
        end
    end

    // Offset, wrap pulse and registered window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= POS_ZERO;
            wrap_q <= 1'b0;
            seg_q  <= {(DIGITS*SYM_W){1'b0}};
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            seg_q  <= seg_d;
        end
    end

    assign seg_out = seg_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;

endmodule
